uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmit engine between NUM_REQ byte-stream requesters.
- Grants one requester per packet and prefixes each packet with a source-ID header byte.
- Enforces a minimum inter-packet idle gap and a stall watchdog.
- Sits between on-chip byte producers and the UART transmitter's valid/ready byte input.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- HEADER_EN, 1, 1 = emit header byte {4'hA, id} before each packet; 0 = no header
- IDLE_GAP, 16, clk cycles of forced idle after each packet end (0 = none)
- STALL_TIMEOUT, 1024, clk cycles a granted requester may hold req_valid low mid-packet before its grant is revoked

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  input  NUM_REQ  marks the final byte of the requester's packet
- req_ready  output  NUM_REQ  byte accepted from requester i
- tx_valid  output  1  byte valid toward the UART transmitter
- tx_data  output  8  byte toward the UART transmitter
- tx_ready  input  1  UART transmitter accepts tx_data
- grant_id  output  clog2(NUM_REQ)  currently granted requester; holds last grant when idle
- busy  output  1  high in every state except IDLE
- abort  output  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset values: req_ready=0, tx_valid=0, tx_data=0, grant_id=0, busy=0, abort=0; state=IDLE; round-robin pointer=0; counters=0.
- Reset is honoured in any state, including mid-packet. Any in-flight byte is dropped and nothing is replayed.
- Handshake rule: a transfer occurs on a cycle where valid and ready are both high. tx_valid, once asserted, holds with stable tx_data until tx_ready.
- IDLE:
  - If any req_valid is high, select the first valid index searching upward from pointer, wrapping.
  - Register the winner into grant_id and set pointer = winner+1 mod NUM_REQ.
  - Go to HDR if HEADER_EN, else DATA.
  - Arbitration costs 1 cycle. No req_ready is asserted in IDLE.
- HDR:
  - tx_valid=1, tx_data = 8'hA0 | grant_id.
  - On tx_ready, go to DATA. req_ready stays 0.
- DATA:
  - tx_valid = req_valid[grant_id]; tx_data = req_data[grant_id].
  - req_ready[grant_id] = tx_ready, combinational pass-through. All other req_ready bits are 0.
  - Zero added latency per data byte.
  - On a transfer with req_last[grant_id]=1, go to GAP (IDLE_GAP>0) or IDLE.
- Stall watchdog (DATA only):
  - The counter increments each cycle req_valid[grant_id]=0 and clears on any cycle it is 1.
  - When the count reaches STALL_TIMEOUT, pulse abort for 1 cycle and go to GAP/IDLE as for a normal packet end.
  - The requester's remaining bytes are treated as a new packet.
- GAP:
  - tx_valid=0; count IDLE_GAP cycles, then go to IDLE.
  - Requests arriving during GAP wait; none are lost, since requesters hold valid.
- Simultaneous requests: the round-robin order guarantees each waiting requester is granted within NUM_REQ packets.
- A requester deasserting req_valid while waiting is not an error; it simply is not selected.
- With a single active requester, it is regranted after each gap.
- Counter widths are clog2(STALL_TIMEOUT+1) and clog2(IDLE_GAP+1). Counters saturate and never wrap.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, HDR, DATA, GAP}
  - HEADER_TAG = 4'hA
  - CLK_FREQUENCY = 50_000_000
  - default BAUD_RATE = 9600
- One sub-module: rr_arbiter (NUM_REQ requests, pointer in, one-hot/index grant out, combinational). It is reusable for the RX-side dispatcher.

Test Plan:
- Single requester 1 sends 3 bytes 11,22,33 (last on 33), tx_ready=1, HEADER_EN=1:
  - tx sequence is A1,11,22,33.
  - busy high through the sequence.
  - tx_valid low for 16 cycles after 33, then IDLE.
- Requesters 0, 2 and 3 all valid with 1-byte packets, after reset:
  - Grant order is 0,2,3.
  - Headers are A0,A2,A3.
  - Gaps of 16 cycles between packets.
- tx_ready backpressure: tx_ready low for 5 cycles during the header and again during byte 2:
  - tx_valid/tx_data stay stable.
  - req_ready[grant] stays low while tx_ready is low.
  - No byte is duplicated or lost.
- Watchdog: granted requester 1 sends byte 55 then drops valid, with STALL_TIMEOUT=8:
  - abort pulses exactly 8 cycles after the drop.
  - State goes to GAP, then requester 2 (valid) is granted next.
- Reset asserted in DATA mid-packet:
  - Next cycle tx_valid=0, req_ready=0, busy=0, grant_id=0.
  - First post-reset grant searches from index 0.
- HEADER_EN=0, IDLE_GAP=0, requesters 0 and 1 both with 2-byte packets back-to-back:
  - No header bytes appear.
  - Exactly 1 IDLE arbitration cycle separates the packets.
  - Grant alternates 0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  localparam logic [3:0] HEADER_TAG    = 4'hA;
  localparam int         CLK_FREQUENCY = 50_000_000;
  localparam int         BAUD_RATE     = 9600;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IW-1:0]      grant_idx
);

  always_comb begin
    int j;
    grant_oh  = '0;
    grant_idx = '0;
    j         = 0;
    // Walk offsets from farthest to nearest so the nearest valid request wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant_oh    = '0;
        grant_oh[j] = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between requesters, one packet per grant
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ       = 4,
  parameter bit  HEADER_EN     = 1'b1,
  parameter int  IDLE_GAP      = 16,
  parameter int  STALL_TIMEOUT = 1024,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 abort
);

  localparam int             SW        = $clog2(STALL_TIMEOUT + 1);
  localparam int             GW        = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [SW-1:0]  STALL_MAX = SW'(STALL_TIMEOUT);
  localparam logic [GW-1:0]  GAP_LAST  = (IDLE_GAP > 0) ? GW'(IDLE_GAP - 1) : '0;
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_REQ - 1);
  localparam state_t         PKT_END   = (IDLE_GAP > 0) ? GAP : IDLE;

  state_t               state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IW-1:0]        arb_idx;
  logic                 cur_valid;
  logic                 cur_last;
  logic [7:0]           cur_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  assign cur_valid = req_valid[grant_q];
  assign cur_last  = req_last[grant_q];
  assign cur_data  = req_data[int'(grant_q)*8 +: 8];
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    stall_d   = '0;
    gap_d     = '0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_oh) begin
          grant_d = arb_idx;
          ptr_d   = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
          state_d = HEADER_EN ? HDR : DATA;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = {HEADER_TAG, 4'(grant_q)};
        if (tx_ready) state_d = DATA;
      end
      DATA: begin
        // Watchdog expiry ends the packet; leftover bytes form a fresh packet later.
        if (stall_q == STALL_MAX) begin
          abort   = 1'b1;
          state_d = PKT_END;
        end else begin
          tx_valid           = cur_valid;
          tx_data            = cur_data;
          req_ready[grant_q] = tx_ready;
          if (!cur_valid) stall_d = stall_q + 1'b1;
          if (cur_valid && tx_ready && cur_last) state_d = PKT_END;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        tx_ready;

  logic [3:0]  rr1, rr2;
  logic        txv1, txv2;
  logic [7:0]  txd1, txd2;
  logic [1:0]  gid1, gid2;
  logic        busy1, busy2;
  logic        abort1, abort2;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .HEADER_EN(1'b1), .IDLE_GAP(16), .STALL_TIMEOUT(8)
  ) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rr1), .tx_valid(txv1), .tx_data(txd1),
    .tx_ready(tx_ready), .grant_id(gid1), .busy(busy1), .abort(abort1)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .HEADER_EN(1'b0), .IDLE_GAP(0), .STALL_TIMEOUT(8)
  ) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rr2), .tx_valid(txv2), .tx_data(txd2),
    .tx_ready(tx_ready), .grant_id(gid2), .busy(busy2), .abort(abort2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Transfer counter on dut1's transmit side, used to catch duplicated or lost bytes.
  int xf1 = 0;
  always @(negedge clk) if (!reset && txv1 && tx_ready) xf1++;

  // Queue-style producers: each requester owns one packet of up to 4 bytes.
  logic [7:0] pk_byte [4][4];
  int         pk_len [4];
  int         pk_idx [4];
  logic       sel;
  logic       m_txv;
  logic [7:0] m_txd;
  logic [3:0] m_rr;
  logic [1:0] m_gid;
  assign m_txv = sel ? txv2 : txv1;
  assign m_txd = sel ? txd2 : txd1;
  assign m_rr  = sel ? rr2  : rr1;
  assign m_gid = sel ? gid2 : gid1;

  logic [7:0] log_d [8];
  int         log_g [8];
  int         log_c [8];
  int         n_log;

  task automatic prod_drive();
    for (int i = 0; i < 4; i++) begin
      if (pk_idx[i] < pk_len[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = pk_byte[i][pk_idx[i]];
        req_last[i]         = (pk_idx[i] == pk_len[i] - 1);
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic run_prod(input int want, input int budget);
    logic [3:0] pop;
    n_log = 0;
    for (int c = 0; c < budget && n_log < want; c++) begin
      sample();
      if (m_txv && tx_ready && n_log < 8) begin
        log_d[n_log] = m_txd;
        log_g[n_log] = int'(m_gid);
        log_c[n_log] = c;
        n_log++;
      end
      pop = req_valid & m_rr;
      next_cycle();
      for (int i = 0; i < 4; i++) if (pop[i]) pk_idx[i]++;
      prod_drive();
    end
    chk("xfer_count", 32'(n_log), 32'(want));
  endtask

  task automatic clear_pk();
    for (int i = 0; i < 4; i++) begin
      pk_len[i] = 0;
      pk_idx[i] = 0;
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    logic [3:0] l;
    logic       rdy;
    logic       e_txv;
    logic [7:0] e_txd;
    logic [3:0] e_rr;
    logic       e_busy;
    logic [1:0] e_gid;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int x0;
    sel = 1'b0;
    clear_pk();

    tbl[0] = '{4'b0010, 8'h11, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[1] = '{4'b0010, 8'h11, 4'b0000, 1'b1, 1'b1, 8'hA1, 4'b0000, 1'b1, 2'd1};
    tbl[2] = '{4'b0010, 8'h11, 4'b0000, 1'b1, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1};
    tbl[3] = '{4'b0010, 8'h22, 4'b0000, 1'b1, 1'b1, 8'h22, 4'b0010, 1'b1, 2'd1};
    tbl[4] = '{4'b0010, 8'h33, 4'b0010, 1'b1, 1'b1, 8'h33, 4'b0010, 1'b1, 2'd1};
    for (int i = 5; i < 21; i++)
      tbl[i] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd1};
    tbl[21] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};

    // Reset state, both instances
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    chk("rst_txv1",  32'(txv1),   32'd0);
    chk("rst_txd1",  32'(txd1),   32'd0);
    chk("rst_rr1",   32'(rr1),    32'd0);
    chk("rst_gid1",  32'(gid1),   32'd0);
    chk("rst_busy1", 32'(busy1),  32'd0);
    chk("rst_abt1",  32'(abort1), 32'd0);
    chk("rst_busy2", 32'(busy2),  32'd0);
    chk("rst_txv2",  32'(txv2),   32'd0);

    // Single requester 1: A1,11,22,33 then a 16-cycle gap
    do_reset();
    for (int i = 0; i < 22; i++) begin
      req_valid = tbl[i].v;
      req_data  = {4{tbl[i].d}};
      req_last  = tbl[i].l;
      tx_ready  = tbl[i].rdy;
      sample();
      chk($sformatf("t1_txv[%0d]", i),  32'(txv1),  32'(tbl[i].e_txv));
      chk($sformatf("t1_txd[%0d]", i),  32'(txd1),  32'(tbl[i].e_txd));
      chk($sformatf("t1_rr[%0d]", i),   32'(rr1),   32'(tbl[i].e_rr));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy1), 32'(tbl[i].e_busy));
      chk($sformatf("t1_gid[%0d]", i),  32'(gid1),  32'(tbl[i].e_gid));
      next_cycle();
    end

    // Round robin 0,2,3 with one-byte packets
    do_reset();
    clear_pk();
    sel = 1'b0;
    pk_byte[0][0] = 8'h10; pk_len[0] = 1;
    pk_byte[2][0] = 8'h12; pk_len[2] = 1;
    pk_byte[3][0] = 8'h13; pk_len[3] = 1;
    prod_drive();
    run_prod(6, 200);
    chk("rr_d0", 32'(log_d[0]), 32'hA0);
    chk("rr_d1", 32'(log_d[1]), 32'h10);
    chk("rr_d2", 32'(log_d[2]), 32'hA2);
    chk("rr_d3", 32'(log_d[3]), 32'h12);
    chk("rr_d4", 32'(log_d[4]), 32'hA3);
    chk("rr_d5", 32'(log_d[5]), 32'h13);
    chk("rr_g1", 32'(log_g[1]), 32'd0);
    chk("rr_g3", 32'(log_g[3]), 32'd2);
    chk("rr_g5", 32'(log_g[5]), 32'd3);
    chk("rr_gap01", 32'(log_c[2] - log_c[1]), 32'd18);
    chk("rr_gap12", 32'(log_c[4] - log_c[3]), 32'd18);

    // Backpressure during header and during byte 2
    do_reset();
    x0 = xf1;
    req_valid = 4'b0010; req_data = {4{8'h11}}; req_last = 4'b0000; tx_ready = 1'b0;
    sample();
    chk("bp_idle_txv", 32'(txv1), 32'd0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("bp_hdr_txv[%0d]", i), 32'(txv1), 32'd1);
      chk($sformatf("bp_hdr_txd[%0d]", i), 32'(txd1), 32'hA1);
      chk($sformatf("bp_hdr_rr[%0d]", i),  32'(rr1),  32'd0);
      next_cycle();
    end
    tx_ready = 1'b1;
    sample();
    chk("bp_hdr_go", 32'(txd1), 32'hA1);
    next_cycle();
    sample();
    chk("bp_b1_txd", 32'(txd1), 32'h11);
    chk("bp_b1_rr",  32'(rr1),  32'b0010);
    next_cycle();
    req_data = {4{8'h22}}; tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("bp_b2_txv[%0d]", i), 32'(txv1), 32'd1);
      chk($sformatf("bp_b2_txd[%0d]", i), 32'(txd1), 32'h22);
      chk($sformatf("bp_b2_rr[%0d]", i),  32'(rr1),  32'd0);
      next_cycle();
    end
    tx_ready = 1'b1;
    sample();
    chk("bp_b2_go", 32'(rr1), 32'b0010);
    next_cycle();
    req_data = {4{8'h33}}; req_last = 4'b0010;
    sample();
    chk("bp_b3_txd", 32'(txd1), 32'h33);
    next_cycle();
    req_valid = '0; req_last = '0;
    sample();
    chk("bp_gap_busy", 32'(busy1), 32'd1);
    chk("bp_gap_txv",  32'(txv1),  32'd0);
    chk("bp_xfers",    32'(xf1 - x0), 32'd4);

    // Stall watchdog on requester 1, then requester 2 takes over
    do_reset();
    req_valid = 4'b0110; req_data = 32'h0077_5500; req_last = 4'b0100; tx_ready = 1'b1;
    next_cycle();
    sample();
    chk("wd_hdr", 32'(txd1), 32'hA1);
    next_cycle();
    sample();
    chk("wd_b55", 32'(txd1), 32'h55);
    next_cycle();
    req_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk($sformatf("wd_abort_lo[%0d]", i), 32'(abort1), 32'd0);
      chk($sformatf("wd_txv_lo[%0d]", i),   32'(txv1),   32'd0);
      next_cycle();
    end
    sample();
    chk("wd_abort_hi", 32'(abort1), 32'd1);
    next_cycle();
    sample();
    chk("wd_abort_pulse", 32'(abort1), 32'd0);
    chk("wd_gap_busy",    32'(busy1),  32'd1);
    for (int i = 0; i < 16; i++) next_cycle();
    sample();
    chk("wd_idle", 32'(busy1), 32'd0);
    next_cycle();
    sample();
    chk("wd_next_gid", 32'(gid1), 32'd2);
    chk("wd_next_hdr", 32'(txd1), 32'hA2);

    // Reset in DATA mid-packet, then re-arbitration from index 0
    do_reset();
    req_valid = 4'b0100; req_data = 32'h0021_0000; req_last = 4'b0000; tx_ready = 1'b1;
    next_cycle();
    sample();
    chk("mr_hdr", 32'(txd1), 32'hA2);
    next_cycle();
    sample();
    chk("mr_data", 32'(txd1), 32'h21);
    next_cycle();
    reset = 1'b1;
    sample();
    chk("mr_busy_pre", 32'(busy1), 32'd1);
    next_cycle();
    reset = 1'b0;
    req_valid = 4'b1010; req_data = '0; req_last = 4'b1010;
    sample();
    chk("mr_txv",  32'(txv1),  32'd0);
    chk("mr_rr",   32'(rr1),   32'd0);
    chk("mr_busy", 32'(busy1), 32'd0);
    chk("mr_gid",  32'(gid1),  32'd0);
    next_cycle();
    sample();
    chk("mr_regrant", 32'(gid1), 32'd1);
    chk("mr_rehdr",   32'(txd1), 32'hA1);

    // No header, no gap: two 2-byte packets alternate 0,1
    do_reset();
    clear_pk();
    sel = 1'b1;
    pk_byte[0][0] = 8'h01; pk_byte[0][1] = 8'h02; pk_len[0] = 2;
    pk_byte[1][0] = 8'h03; pk_byte[1][1] = 8'h04; pk_len[1] = 2;
    prod_drive();
    run_prod(4, 100);
    chk("nh_d0", 32'(log_d[0]), 32'h01);
    chk("nh_d1", 32'(log_d[1]), 32'h02);
    chk("nh_d2", 32'(log_d[2]), 32'h03);
    chk("nh_d3", 32'(log_d[3]), 32'h04);
    chk("nh_g0", 32'(log_g[0]), 32'd0);
    chk("nh_g2", 32'(log_g[2]), 32'd1);
    chk("nh_first", 32'(log_c[0]), 32'd1);
    chk("nh_idle1", 32'(log_c[2] - log_c[1]), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
